// File: rtl/taxi_axil_pkg.sv
// ============================================================================
// Module : taxi_axil_pkg
// Brief  : Shared AXI4-lite response codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package taxi_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/taxi_axil_regfile_pkg.sv
// ============================================================================
// Module : taxi_axil_regfile_pkg
// Brief  : Write-FSM state encoding and address helper for the register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package taxi_axil_regfile_pkg;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;

  // Number of byte-offset bits below the register index.
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/taxi_axil_if.sv
// ============================================================================
// Module : taxi_axil_if
// Brief  : AXI4-lite bus bundle with separate write/read modports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int USER_W = 1
);

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic [USER_W-1:0] awuser;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [USER_W-1:0] wuser;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [USER_W-1:0] ruser;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awprot, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wuser, wvalid,
    output wready,
    output bresp, buser, bvalid,
    input  bready
  );

  modport rd_slv (
    input  araddr, arprot, aruser, arvalid,
    output arready,
    output rdata, rresp, ruser, rvalid,
    input  rready
  );

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wuser, wvalid,
    input  wready,
    input  bresp, buser, bvalid,
    output bready
  );

  modport rd_mst (
    output araddr, arprot, aruser, arvalid,
    input  arready,
    input  rdata, rresp, ruser, rvalid,
    output rready
  );

endinterface

`default_nettype wire

// File: rtl/taxi_axil_regfile_wr_join.sv
// ============================================================================
// Module : taxi_axil_regfile_wr_join
// Brief  : One-deep AW and W holding registers, filled independently and
//          emptied together once the write response has been accepted.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module taxi_axil_regfile_wr_join #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic              clr_i,
  output logic              aw_full_o,
  output logic              w_full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [STRB_W-1:0] strb_o
);

  logic              aw_full_q;
  logic              w_full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;

  // Readys are gated by reset so nothing is accepted while it is held.
  assign awready_o = rst && !aw_full_q;
  assign wready_o  = rst && !w_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else if (clr_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
    end else begin
      if (awvalid_i && awready_o) begin
        aw_full_q <= 1'b1;
        addr_q    <= awaddr_i;
      end
      if (wvalid_i && wready_o) begin
        w_full_q <= 1'b1;
        data_q   <= wdata_i;
        strb_q   <= wstrb_i;
      end
    end
  end

  assign aw_full_o = aw_full_q;
  assign w_full_o  = w_full_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign strb_o    = strb_q;

endmodule

`default_nettype wire

// File: rtl/taxi_axil_regfile.sv
// ============================================================================
// Module : taxi_axil_regfile
// Brief  : AXI4-lite register file with RW/RO registers and write strobes.
//          Define TAXI_AXIL_REGFILE_RD_PIPE_EN for a two-stage read path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module taxi_axil_regfile
  import taxi_axil_pkg::*;
  import taxi_axil_regfile_pkg::*;
#(
  parameter int                          DATA_W    = 32,
  parameter int                          ADDR_W    = 16,
  parameter int                          REG_COUNT = 16,
  parameter logic [REG_COUNT-1:0]        RO_MASK   = '0,
  parameter logic [REG_COUNT*DATA_W-1:0] RST_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  taxi_axil_if.wr_slv                   s_axil_wr,
  taxi_axil_if.rd_slv                   s_axil_rd,
  output logic [REG_COUNT*DATA_W-1:0]   reg_out,
  input  logic [REG_COUNT*DATA_W-1:0]   reg_in,
  output logic [REG_COUNT-1:0]          wr_pulse
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

  logic              w_aw_full;
  logic              w_w_full;
  logic              w_clr;
  logic              w_awready;
  logic              w_wready;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;

  taxi_axil_regfile_wr_join #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .STRB_W (STRB_W)
  ) u_wr_join (
    .clk       (clk),
    .rst       (rst),
    .awaddr_i  (s_axil_wr.awaddr),
    .awvalid_i (s_axil_wr.awvalid),
    .awready_o (w_awready),
    .wdata_i   (s_axil_wr.wdata),
    .wstrb_i   (s_axil_wr.wstrb),
    .wvalid_i  (s_axil_wr.wvalid),
    .wready_o  (w_wready),
    .clr_i     (w_clr),
    .aw_full_o (w_aw_full),
    .w_full_o  (w_w_full),
    .addr_o    (w_wr_addr),
    .data_o    (w_wr_data),
    .strb_o    (w_wr_strb)
  );

  logic [0:0]        state_q, state_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] wr_pulse_q, wr_pulse_d;

  logic [IDX_W-1:0]     w_wr_idx;
  logic [REG_COUNT-1:0] w_wr_sel;
  logic                 w_wr_hit;
  logic                 w_wr_ro;

  assign w_wr_idx = w_wr_addr[ADDR_W-1:ADDR_LSB];

  always_comb begin
    w_wr_sel = '0;
    w_wr_hit = 1'b0;
    w_wr_ro  = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (w_wr_idx == IDX_W'(i)) begin
        w_wr_sel[i] = 1'b1;
        w_wr_hit    = 1'b1;
        w_wr_ro     = RO_MASK[i];
      end
    end
  end

  // The write is committed in the IDLE cycle that sees both holders full.
  always_comb begin
    state_d    = state_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    w_clr      = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (w_aw_full && w_w_full) begin
          state_d = WR_RESP;
          if (!w_wr_hit) begin
            bresp_d = RESP_DECERR;
          end else if (w_wr_ro) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d    = RESP_OKAY;
            wr_pulse_d = w_wr_sel;
            for (int i = 0; i < REG_COUNT; i++) begin
              if (w_wr_sel[i]) begin
                for (int b = 0; b < STRB_W; b++) begin
                  if (w_wr_strb[b]) begin
                    regs_d[i][b*8 +: 8] = w_wr_data[b*8 +: 8];
                  end
                end
              end
            end
          end
        end
      end
      WR_RESP: begin
        if (s_axil_wr.bready) begin
          state_d = WR_IDLE;
          w_clr   = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WR_IDLE;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      state_q    <= state_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign s_axil_wr.awready = w_awready;
  assign s_axil_wr.wready  = w_wready;
  assign s_axil_wr.bvalid  = (state_q == WR_RESP);
  assign s_axil_wr.bresp   = bresp_q;
  assign s_axil_wr.buser   = '0;
  assign wr_pulse          = wr_pulse_q;

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg_out
    assign reg_out[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

  // Read side: the mux sees pre-write register contents in a shared cycle.
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        w_rd_resp;
  logic              w_arready;
  logic              w_ar_hs;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  assign w_rd_idx = s_axil_rd.araddr[ADDR_W-1:ADDR_LSB];

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_DECERR;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (w_rd_idx == IDX_W'(i)) begin
        w_rd_resp = RESP_OKAY;
        w_rd_data = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  assign w_ar_hs = s_axil_rd.arvalid && w_arready;

`ifdef TAXI_AXIL_REGFILE_RD_PIPE_EN
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [1:0]        s1_resp_q;

  assign w_arready = rst && !rvalid_q && !s1_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_resp_q  <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      if (rvalid_q && s_axil_rd.rready) begin
        rvalid_q <= 1'b0;
      end
      if (s1_valid_q) begin
        s1_valid_q <= 1'b0;
        rvalid_q   <= 1'b1;
        rdata_q    <= s1_data_q;
        rresp_q    <= s1_resp_q;
      end
      if (w_ar_hs) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= w_rd_data;
        s1_resp_q  <= w_rd_resp;
      end
    end
  end
`else
  assign w_arready = rst && !rvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (rvalid_q && s_axil_rd.rready) begin
        rvalid_q <= 1'b0;
      end
      if (w_ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= w_rd_data;
        rresp_q  <= w_rd_resp;
      end
    end
  end
`endif

  assign s_axil_rd.arready = w_arready;
  assign s_axil_rd.rvalid  = rvalid_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.rresp   = rresp_q;
  assign s_axil_rd.ruser   = '0;

  logic w_unused;
  assign w_unused = ^{s_axil_wr.awprot, s_axil_wr.awuser, s_axil_wr.wuser,
                      s_axil_rd.arprot, s_axil_rd.aruser,
                      w_wr_addr[ADDR_LSB-1:0], s_axil_rd.araddr[ADDR_LSB-1:0]};

endmodule

`default_nettype wire

// File: doc/taxi_axil_regfile.md
TAXI_AXIL_REGFILE -- requirements
Module: taxi_axil_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 16, byte address width.
REQ-003 SHALL have parameter REG_COUNT, default 16, number of word registers (1..256).
REQ-004 SHALL have parameter RO_MASK, default '0, REG_COUNT bits; bit set = register read-only (reflects reg_in).
REQ-005 SHALL have parameter RST_VAL, default '0, REG_COUNT*DATA_W bits; reset value of each RW register.
REQ-006 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port s_axil_wr  taxi_axil_if.wr_slv  -  AXI4-lite write slave, driven by a crossbar master port.
REQ-009 SHALL have port s_axil_rd  taxi_axil_if.rd_slv  -  AXI4-lite read slave, driven by a crossbar master port.
REQ-010 SHALL have port reg_out  output  REG_COUNT x DATA_W  current RW register contents.
REQ-011 SHALL have port reg_in  input  REG_COUNT x DATA_W  status values returned for RO registers.
REQ-012 SHALL have port wr_pulse  output  REG_COUNT  one-cycle strobe per successfully written register.

Function
REQ-013 SHALL decode register index as addr[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits ignored.
REQ-014 SHALL capture AW and W independently into one-deep holding registers; awready high only when AW holder empty, wready only when W holder empty.
REQ-015 SHALL run a write FSM WR_IDLE -> WR_RESP: leave WR_IDLE when both holders full, performing the write in that cycle; return to WR_IDLE on bvalid && bready, clearing both holders.
REQ-016 SHALL hold bvalid and bresp stable until bready; bvalid asserts the cycle after the write.
REQ-017 SHALL, for index >= REG_COUNT, return bresp DECERR (2'b11) with no register change and no wr_pulse.
REQ-018 SHALL, for a RO register, return bresp SLVERR (2'b10) with no register change and no wr_pulse.
REQ-019 SHALL otherwise update only bytes whose wstrb bit is set, return OKAY, and pulse wr_pulse[index] for exactly one cycle, including wstrb == 0.
REQ-020 SHALL accept AR when no read response is pending (arready = !rvalid && pipeline empty); rvalid asserts one cycle after the AR handshake.
REQ-021 SHALL return reg_out for RW, reg_in sampled at the AR handshake for RO, and rdata 0 with rresp DECERR for out-of-range indices.
REQ-022 SHALL hold rvalid, rdata and rresp stable until rready.
REQ-023 SHALL, when a read and a write of the same register occur in the same cycle, return the pre-write value.
REQ-024 SHALL ignore awprot/arprot and user fields; buser and ruser are driven 0.

Reset
REQ-025 SHALL, while rst is low, force reg_out = RST_VAL, wr_pulse = 0, bvalid = rvalid = 0, awready = wready = arready = 0, both holders empty, FSM in WR_IDLE.
REQ-026 SHALL drop in-flight transactions when reset asserts mid-operation and restart cleanly on deassertion, with readys high on the first cycle after deassertion.

Configuration
REQ-027 SHALL support macro TAXI_AXIL_REGFILE_RD_PIPE_EN; when defined, read data is registered twice, giving a two-cycle AR-to-rvalid latency, with arready low while either stage is occupied.
REQ-028 SHALL, without TAXI_AXIL_REGFILE_RD_PIPE_EN, use the one-cycle read latency of REQ-020; write behaviour is identical in both builds.

Structure
REQ-029 SHALL take the response codes OKAY, EXOKAY, SLVERR and DECERR from the shared package taxi_axil_pkg; no local literals.
REQ-030 SHALL place the AW/W holding-register join in one sub-module, taxi_axil_regfile_wr_join, with everything else in the top module.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to byte addr 0x08 with wstrb 0xF -> bresp OKAY, reg_out[2] = 0xDEADBEEF, wr_pulse[2] high for one cycle; read 0x08 -> 0xDEADBEEF after 1 cycle (2 with macro).
REQ-032 SHALL cover: W presented 5 cycles before AW -> single write on the AW handshake; wstrb 0x2 with data 0x0000AB00 onto 0x11223344 -> 0x1122AB44.
REQ-033 SHALL cover: write and read of addr 0x40 with REG_COUNT 16 -> bresp DECERR, rresp DECERR, rdata 0, no wr_pulse.
REQ-034 SHALL cover: RO_MASK bit 3 set, reg_in[3] = 0x5A5A5A5A -> write returns SLVERR with no change; read returns 0x5A5A5A5A.
REQ-035 SHALL cover: bready held low for 10 cycles -> bvalid and bresp stable, awready low, no second write accepted.
REQ-036 SHALL cover: rst asserted during WR_RESP -> bvalid 0 immediately, reg_out = RST_VAL; normal write accepted after release.
